// File: rtl/imm_stage_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// imm_stage_ctrl_pkg
// Shared types for the ID->EXE immediate stage controller:
//   - extop_t and the four extension opcode constants
//   - state_t, the buffering FSM state
//   - imm_entry_t, one stored result {imm32, pc, bad}
// ENTRY_PC_W is the PC width carried inside imm_entry_t; the top-level PC_W
// parameter is expected to match it.
// -----------------------------------------------------------------------------
package imm_stage_ctrl_pkg;

    localparam int ENTRY_PC_W = 32;

    typedef logic [1:0] extop_t;

    localparam extop_t EXTOP_ZERO = 2'b00;
    localparam extop_t EXTOP_SIGN = 2'b01;
    localparam extop_t EXTOP_LUI  = 2'b10;
    localparam extop_t EXTOP_BAD  = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_HALF  = 2'b01,
        ST_FULL  = 2'b10
    } state_t;

    typedef struct packed {
        logic [31:0]           imm32;
        logic [ENTRY_PC_W-1:0] pc;
        logic                  bad;
    } imm_entry_t;

endpackage

// File: rtl/imm_stage_ctrl_extender.sv
// -----------------------------------------------------------------------------
// imm_extender
// Purely combinational 16->32 bit immediate extension.
// Ports:
//   imm16  in  16  raw immediate field
//   extop  in  2   extension opcode (ZERO/SIGN/LUI, 2'b11 illegal)
//   imm32  out 32  extended immediate (0 for the illegal opcode)
//   bad    out 1   set when extop is the illegal opcode
// -----------------------------------------------------------------------------
module imm_extender
    import imm_stage_ctrl_pkg::*;
(
    input  logic [15:0] imm16,
    input  logic [1:0]  extop,
    output logic [31:0] imm32,
    output logic        bad
);

    always_comb begin
        imm32 = 32'h0;
        bad   = 1'b0;
        case (extop)
            EXTOP_ZERO: imm32 = {16'h0, imm16};
            EXTOP_SIGN: imm32 = {{16{imm16[15]}}, imm16};
            EXTOP_LUI:  imm32 = {imm16, 16'h0};
            default:    bad   = 1'b1;
        endcase
    end

endmodule

// File: rtl/imm_stage_ctrl.sv
// -----------------------------------------------------------------------------
// imm_stage_ctrl
// ID->EXE immediate stage: accepts decoded immediate requests over a
// valid/ready handshake, extends them on the input side, registers the
// result and presents it to EXE over a second valid/ready handshake.
//
// Build option (macro IMM_STAGE_SKID_EN):
//   defined   - two entries (main + skid), three-state FSM, registered in_ready
//   undefined - single entry, in_ready = !out_valid | out_ready
//
// Ports:
//   clk           in   rising-edge clock
//   resetn        in   asynchronous active-low reset
//   flush         in   synchronous flush, drops all entries not yet transferred
//   in_valid      in   ID presents a request
//   in_ready      out  block can accept this cycle
//   in_imm16      in   raw immediate
//   in_extop      in   extension opcode
//   in_pc         in   PC of the instruction
//   out_valid     out  result valid towards EXE
//   out_ready     in   EXE accepts
//   out_imm32     out  extended immediate
//   out_pc        out  PC of the result
//   out_bad_extop out  result came from an illegal opcode
// -----------------------------------------------------------------------------
module imm_stage_ctrl
    import imm_stage_ctrl_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [15:0]     in_imm16,
    input  logic [1:0]      in_extop,
    input  logic [PC_W-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_imm32,
    output logic [PC_W-1:0] out_pc,
    output logic            out_bad_extop
);

    state_t     state;
    state_t     state_next;
    imm_entry_t in_entry;
    imm_entry_t main_p0;
    logic       in_fire;
    logic       out_fire;
    logic       load_main;
    logic [31:0] ext_imm32;
    logic        ext_bad;

    imm_extender u_ext (
        .imm16 (in_imm16),
        .extop (in_extop),
        .imm32 (ext_imm32),
        .bad   (ext_bad)
    );

    always_comb begin
        in_entry       = '0;
        in_entry.imm32 = ext_imm32;
        in_entry.pc    = ENTRY_PC_W'(in_pc);
        in_entry.bad   = ext_bad;
    end

    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

`ifdef IMM_STAGE_SKID_EN
    imm_entry_t skid_p0;
    logic       load_skid;
    logic       shift_skid;
    logic       in_ready_q;
`endif

    // Next-state / load control. flush wins: any in_fire that cycle is
    // dropped, while an out_fire still counts as taken by EXE.
    always_comb begin
        state_next = state;
        load_main  = 1'b0;
`ifdef IMM_STAGE_SKID_EN
        load_skid  = 1'b0;
        shift_skid = 1'b0;
`endif
        if (flush) begin
            state_next = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_next = ST_HALF;
                        load_main  = 1'b1;
                    end
                end
                ST_HALF: begin
                    if (in_fire && out_fire) begin
                        load_main = 1'b1;
                    end
`ifdef IMM_STAGE_SKID_EN
                    else if (in_fire) begin
                        state_next = ST_FULL;
                        load_skid  = 1'b1;
                    end
`endif
                    else if (out_fire) begin
                        state_next = ST_EMPTY;
                    end
                end
`ifdef IMM_STAGE_SKID_EN
                ST_FULL: begin
                    // in_ready is low in FULL, so only a drain can happen.
                    if (out_fire) begin
                        state_next = ST_HALF;
                        shift_skid = 1'b1;
                    end
                end
`endif
                default: state_next = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_next;
        end
    end

    // Stage p0: main entry (always presented) and, with skid, the second entry.
`ifdef IMM_STAGE_SKID_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            main_p0    <= '0;
            skid_p0    <= '0;
            in_ready_q <= 1'b1;
        end else begin
            if (load_main) begin
                main_p0 <= in_entry;
            end else if (shift_skid) begin
                main_p0 <= skid_p0;
            end
            if (load_skid) begin
                skid_p0 <= in_entry;
            end
            in_ready_q <= (state_next != ST_FULL);
        end
    end

    assign in_ready = in_ready_q;
`else
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            main_p0 <= '0;
        end else if (load_main) begin
            main_p0 <= in_entry;
        end
    end

    // Single entry: a slot frees up in the same cycle EXE takes the result.
    assign in_ready = !out_valid | out_ready;
`endif

    assign out_valid     = (state != ST_EMPTY);
    assign out_imm32     = main_p0.imm32;
    assign out_pc        = PC_W'(main_p0.pc);
    assign out_bad_extop = main_p0.bad;

endmodule

// File: tb/tb_imm_stage_ctrl.sv
module tb_imm_stage_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_imm16;
    logic [1:0]  in_extop;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm32;
    logic [31:0] out_pc;
    logic        out_bad_extop;

    int checks   = 0;
    int failures = 0;

    imm_stage_ctrl #(.PC_W(32)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_imm16      (in_imm16),
        .in_extop      (in_extop),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_imm32     (out_imm32),
        .out_pc        (out_pc),
        .out_bad_extop (out_bad_extop)
    );

    always #5 clk = ~clk;

    // Advance one edge, then settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] imm, input logic [1:0] op,
                         input logic [31:0] pc);
        in_valid = v;
        in_imm16 = imm;
        in_extop = op;
        in_pc    = pc;
    endtask

    task automatic test_reset();
        resetn = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 16'h0, 2'b00, 32'h0);
        tick(); tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
        checks++; if (out_imm32 !== 32'h0) begin failures++; $display("FAIL reset_out_imm32 got=%h exp=00000000", out_imm32); end
        checks++; if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_out_pc got=%h exp=00000000", out_pc); end
        checks++; if (out_bad_extop !== 1'b0) begin failures++; $display("FAIL reset_out_bad got=%0b exp=0", out_bad_extop); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
        resetn = 1'b1;
    endtask

    task automatic test_extend();
        logic [1:0]  ops [3] = '{2'b01, 2'b00, 2'b10};
        logic [31:0] exps[3] = '{32'hFFFF8001, 32'h00008001, 32'h80010000};
        for (int i = 0; i < 3; i++) begin
            out_ready = 1'b1;
            drive(1'b1, 16'h8001, ops[i], 32'h1000 + i);
            tick();
            drive(1'b0, 16'h0, 2'b00, 32'h0);
            checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL ext%0d_valid got=%0b exp=1", i, out_valid); end
            checks++; if (out_imm32 !== exps[i]) begin failures++; $display("FAIL ext%0d_imm32 got=%h exp=%h", i, out_imm32, exps[i]); end
            checks++; if (out_bad_extop !== 1'b0) begin failures++; $display("FAIL ext%0d_bad got=%0b exp=0", i, out_bad_extop); end
            checks++; if (out_pc !== 32'h1000 + i) begin failures++; $display("FAIL ext%0d_pc got=%h exp=%h", i, out_pc, 32'h1000 + i); end
            tick();
            checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ext%0d_drain got=%0b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_bad_extop();
        int seen = 0;
        out_ready = 1'b1;
        drive(1'b1, 16'h1234, 2'b11, 32'h2000);
        tick();
        drive(1'b0, 16'h0, 2'b00, 32'h0);
        checks++; if (out_imm32 !== 32'h0) begin failures++; $display("FAIL bad_imm32 got=%h exp=00000000", out_imm32); end
        checks++; if (out_bad_extop !== 1'b1) begin failures++; $display("FAIL bad_flag got=%0b exp=1", out_bad_extop); end
        for (int c = 0; c < 4; c++) begin
            if (out_valid === 1'b1) seen++;
            tick();
        end
        checks++; if (seen != 1) begin failures++; $display("FAIL bad_deliver_count got=%0d exp=1", seen); end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 16'(i * 3), 2'b00, 32'h100 + 4 * i);
            checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b%0d_in_ready got=%0b exp=1", i, in_ready); end
            tick();
            checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 + 4 * i || out_imm32 !== 32'(i * 3)) begin
                failures++;
                $display("FAIL b2b%0d_out got=v%0b pc=%h imm=%h exp=v1 pc=%h imm=%h",
                         i, out_valid, out_pc, out_imm32, 32'h100 + 4 * i, 32'(i * 3));
            end
        end
        drive(1'b0, 16'h0, 2'b00, 32'h0);
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        drive(1'b1, 16'hAAAA, 2'b00, 32'hA0);
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hA0) begin failures++; $display("FAIL bp_A_held got=v%0b pc=%h exp=v1 pc=000000a0", out_valid, out_pc); end
`ifdef IMM_STAGE_SKID_EN
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_half_ready got=%0b exp=1", in_ready); end
        drive(1'b1, 16'hBBBB, 2'b00, 32'hB0);
        tick();
        drive(1'b0, 16'h0, 2'b00, 32'h0);
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_ready got=%0b exp=0", in_ready); end
        checks++; if (out_pc !== 32'hA0 || out_imm32 !== 32'h0000AAAA) begin failures++; $display("FAIL bp_A_stable got=pc %h imm %h exp=pc 000000a0 imm 0000aaaa", out_pc, out_imm32); end
        out_ready = 1'b1;
        tick();
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hB0 || out_imm32 !== 32'h0000BBBB) begin failures++; $display("FAIL bp_B_next got=v%0b pc=%h imm=%h exp=v1 pc=000000b0 imm=0000bbbb", out_valid, out_pc, out_imm32); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_back got=%0b exp=1", in_ready); end
        tick();
`else
        checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_ready_low got=%0b exp=0", in_ready); end
        drive(1'b1, 16'hBBBB, 2'b00, 32'hB0);
        tick();
        checks++; if (out_pc !== 32'hA0 || out_imm32 !== 32'h0000AAAA) begin failures++; $display("FAIL bp_A_stable got=pc %h imm %h exp=pc 000000a0 imm 0000aaaa", out_pc, out_imm32); end
        out_ready = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_comb got=%0b exp=1", in_ready); end
        tick();
        drive(1'b0, 16'h0, 2'b00, 32'h0);
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'hB0 || out_imm32 !== 32'h0000BBBB) begin failures++; $display("FAIL bp_B_next got=v%0b pc=%h imm=%h exp=v1 pc=000000b0 imm=0000bbbb", out_valid, out_pc, out_imm32); end
        tick();
`endif
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_drain got=%0b exp=0", out_valid); end
    endtask

    task automatic test_flush_held();
        int seen = 0;
        out_ready = 1'b0;
        drive(1'b1, 16'h00A1, 2'b00, 32'h300);
        tick();
`ifdef IMM_STAGE_SKID_EN
        drive(1'b1, 16'h00B1, 2'b00, 32'h304);
        tick();
`endif
        drive(1'b1, 16'h00C1, 2'b00, 32'h308);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, 2'b00, 32'h0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_held_valid got=%0b exp=0", out_valid); end
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            if (out_valid === 1'b1) seen++;
            tick();
        end
        checks++; if (seen != 0) begin failures++; $display("FAIL flush_held_leak got=%0d exp=0", seen); end
    endtask

    task automatic test_flush_fire();
        out_ready = 1'b1;
        drive(1'b1, 16'h00D1, 2'b00, 32'h400);
        tick();
        drive(1'b1, 16'h00E1, 2'b00, 32'h404);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 16'h0, 2'b00, 32'h0);
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_fire_valid got=%0b exp=0", out_valid); end
        tick();
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_fire_later got=%0b exp=0", out_valid); end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(1'b1, 16'h5555, 2'b10, 32'h500);
        tick();
        drive(1'b0, 16'h0, 2'b00, 32'h0);
        checks++; if (out_valid !== 1'b1 || out_imm32 !== 32'h55550000) begin failures++; $display("FAIL ares_pre got=v%0b imm=%h exp=v1 imm=55550000", out_valid, out_imm32); end
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL ares_valid got=%0b exp=0", out_valid); end
        checks++; if (out_imm32 !== 32'h0) begin failures++; $display("FAIL ares_imm32 got=%h exp=00000000", out_imm32); end
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL ares_in_ready got=%0b exp=1", in_ready); end
        drive(1'b1, 16'h0042, 2'b01, 32'h600);
        out_ready = 1'b1;
        #1;
        resetn = 1'b1;
        tick();
        drive(1'b0, 16'h0, 2'b00, 32'h0);
        checks++; if (out_valid !== 1'b1 || out_imm32 !== 32'h00000042 || out_pc !== 32'h600) begin
            failures++;
            $display("FAIL ares_resume got=v%0b imm=%h pc=%h exp=v1 imm=00000042 pc=00000600", out_valid, out_imm32, out_pc);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_extend();
        test_bad_extop();
        test_back_to_back();
        test_backpressure();
        test_flush_held();
        test_flush_fire();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
